mvu_apb_cfg_sequencer: RTL and testbench



---
 rtl/mvu_apb_seq_pkg.sv | 39 +++
 rtl/mvu_apb_seq_cmd_ram.sv | 25 ++
 rtl/mvu_apb_cfg_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_mvu_apb_cfg_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvu_apb_seq_pkg.sv
// Shared types and constants for the APB configuration sequencer.
// Default APB widths match the MVU array wrapper's APB slave.
package mvu_apb_seq_pkg;

  localparam int OP_W           = 3;
  localparam int ERR_W          = 3;
  localparam int APB_ADDR_WIDTH = 32;
  localparam int APB_DATA_WIDTH = 32;

  typedef enum logic [OP_W-1:0] {
    OP_END        = 3'd0,
    OP_WRITE      = 3'd1,
    OP_READ_CHECK = 3'd2,
    OP_SET_MASK   = 3'd3,
    OP_WAIT_IRQ   = 3'd4,
    OP_DELAY      = 3'd5
  } op_e;

  typedef enum logic [ERR_W-1:0] {
    ERR_NONE     = 3'd0,
    ERR_SLVERR   = 3'd1,
    ERR_MISMATCH = 3'd2,
    ERR_TIMEOUT  = 3'd3,
    ERR_BAD_OP   = 3'd4,
    ERR_OVERRUN  = 3'd5
  } err_e;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_SETUP, S_ACCESS,
    S_WAITIRQ, S_DELAY, S_DONE, S_ERROR
  } state_e;

  typedef struct packed {
    op_e                       op;
    logic [APB_ADDR_WIDTH-1:0] addr;
    logic [APB_DATA_WIDTH-1:0] data;
  } cmd_t;

endpackage

// File: rtl/mvu_apb_seq_cmd_ram.sv
// Command script store: one synchronous write port, one registered read port.
module mvu_apb_seq_cmd_ram #(
  parameter int WIDTH = 67,
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mvu_apb_cfg_sequencer.sv
// APB master that replays a loaded command script to configure and run MVUs,
// with irq waits, masked read-back checks, delays, watchdog and error capture.
module mvu_apb_cfg_sequencer
  import mvu_apb_seq_pkg::*;
#(
  parameter int N_MVU     = 8,
  parameter int CMD_DEPTH = 64,
  parameter int ADDR_W    = APB_ADDR_WIDTH,
  parameter int DATA_W    = APB_DATA_WIDTH,
  parameter int TIMEOUT_W = 20,
  localparam int PC_W     = $clog2(CMD_DEPTH),
  localparam int CMD_W    = OP_W + ADDR_W + DATA_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_we,
  input  logic [PC_W-1:0]      cmd_waddr,
  input  logic [CMD_W-1:0]     cmd_wdata,
  input  logic                 start,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  input  logic [N_MVU-1:0]     irq,
  output logic [ADDR_W-1:0]    paddr,
  output logic                 psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [DATA_W-1:0]    pwdata,
  input  logic [DATA_W-1:0]    prdata,
  input  logic                 pready,
  input  logic                 pslverr,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [ERR_W-1:0]     err_code,
  output logic [PC_W-1:0]      err_pc
);

  state_e               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [DATA_W-1:0]    mask_q, mask_d;
  logic [N_MVU-1:0]     irq_seen_q, irq_seen_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d, wd_inc;
  logic [DATA_W-1:0]    dly_q, dly_d;
  logic [ERR_W-1:0]     err_code_q, err_code_d;
  logic [PC_W-1:0]      err_pc_q, err_pc_d;
  logic                 psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]    paddr_q, paddr_d;
  logic [DATA_W-1:0]    pwdata_q, pwdata_d;

  logic [CMD_W-1:0]  rd_data;
  op_e               rd_op;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_dat;
  logic [N_MVU-1:0]  irq_sel;
  logic              wd_hit, advance, fail;
  err_e              fail_code;

  mvu_apb_seq_cmd_ram #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_ram (
    .clk_i   (clk),
    .we_i    (cmd_we && !busy),
    .waddr_i (cmd_waddr),
    .wdata_i (cmd_wdata),
    .raddr_i (pc_q),
    .rdata_o (rd_data)
  );

  assign rd_op   = op_e'(rd_data[CMD_W-1 -: OP_W]);
  assign rd_addr = rd_data[DATA_W +: ADDR_W];
  assign rd_dat  = rd_data[DATA_W-1:0];
  assign irq_sel = data_q[N_MVU-1:0];
  assign busy    = !(state_q inside {S_IDLE, S_DONE, S_ERROR});

  // wd_inc counts the current cycle, so a limit of N allows exactly N cycles.
  assign wd_inc = wd_q + 1'b1;
  assign wd_hit = (timeout_cycles != '0) && (wd_inc == timeout_cycles);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mask_d     = mask_q;
    irq_seen_d = busy ? (irq_seen_q | irq) : irq_seen_q;
    data_d     = data_q;
    wd_d       = wd_q;
    dly_d      = dly_q;
    err_code_d = err_code_q;
    err_pc_d   = err_pc_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    pwrite_d   = pwrite_q;
    advance    = 1'b0;
    fail       = 1'b0;
    fail_code  = ERR_NONE;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d    = S_FETCH;
          pc_d       = '0;
          irq_seen_d = '0;
          mask_d     = '1;
          err_code_d = '0;
          err_pc_d   = '0;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        data_d = rd_dat;
        case (rd_op)
          OP_WRITE, OP_READ_CHECK: begin
            state_d  = S_SETUP;
            paddr_d  = rd_addr;
            pwdata_d = rd_dat;
            pwrite_d = (rd_op == OP_WRITE);
          end
          OP_SET_MASK: begin
            mask_d  = rd_dat;
            advance = 1'b1;
          end
          OP_WAIT_IRQ: begin
            state_d = S_WAITIRQ;
            wd_d    = '0;
          end
          OP_DELAY: begin
            state_d = S_DELAY;
            dly_d   = '0;
          end
          OP_END: state_d = S_DONE;
          default: begin
            fail      = 1'b1;
            fail_code = ERR_BAD_OP;
          end
        endcase
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        wd_d    = '0;
      end
      S_ACCESS: begin
        wd_d = wd_inc;
        // A completing transfer wins over a watchdog expiring in the same cycle.
        if (pready) begin
          if (pslverr) begin
            fail      = 1'b1;
            fail_code = ERR_SLVERR;
          end else if (!pwrite_q && ((prdata ^ data_q) & mask_q) != '0) begin
            fail      = 1'b1;
            fail_code = ERR_MISMATCH;
          end else begin
            advance = 1'b1;
          end
        end else if (wd_hit) begin
          fail      = 1'b1;
          fail_code = ERR_TIMEOUT;
        end
      end
      S_WAITIRQ: begin
        wd_d = wd_inc;
        if ((irq_seen_q & irq_sel) == irq_sel) begin
          advance    = 1'b1;
          irq_seen_d = (irq_seen_q | irq) & ~irq_sel;
        end else if (wd_hit) begin
          fail      = 1'b1;
          fail_code = ERR_TIMEOUT;
        end
      end
      S_DELAY: begin
        if (dly_q == data_q) advance = 1'b1;
        else dly_d = dly_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Stepping past the last entry without an END is itself an error.
    if (advance) begin
      if (pc_q == PC_W'(CMD_DEPTH - 1)) begin
        fail      = 1'b1;
        fail_code = ERR_OVERRUN;
      end else begin
        pc_d    = pc_q + 1'b1;
        state_d = S_FETCH;
      end
    end

    if (fail) begin
      state_d    = S_ERROR;
      err_code_d = fail_code;
      err_pc_d   = pc_q;
    end

    psel_d    = (state_d == S_SETUP) || (state_d == S_ACCESS);
    penable_d = (state_d == S_ACCESS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      mask_q     <= '1;
      irq_seen_q <= '0;
      data_q     <= '0;
      wd_q       <= '0;
      dly_q      <= '0;
      err_code_q <= '0;
      err_pc_q   <= '0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mask_q     <= mask_d;
      irq_seen_q <= irq_seen_d;
      data_q     <= data_d;
      wd_q       <= wd_d;
      dly_q      <= dly_d;
      err_code_q <= err_code_d;
      err_pc_q   <= err_pc_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
    end
  end

  assign psel     = psel_q;
  assign penable  = penable_q;
  assign pwrite   = pwrite_q;
  assign paddr    = paddr_q;
  assign pwdata   = pwdata_q;
  assign done     = (state_q == S_DONE);
  assign err      = (state_q == S_ERROR);
  assign err_code = err_code_q;
  assign err_pc   = err_pc_q;

endmodule

// File: tb/tb_mvu_apb_cfg_sequencer.sv
// Scoreboard bench: a script-level reference model predicts APB transfers and
// run outcome (flags, code, pc, busy length); a monitor checks them as they occur.
module tb_mvu_apb_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_we;
  logic [5:0]  cmd_waddr;
  logic [66:0] cmd_wdata;
  logic        start;
  logic [19:0] timeout_cycles;
  logic [7:0]  irq;
  logic [31:0] paddr, pwdata, prdata;
  logic        psel, penable, pwrite, pready, pslverr;
  logic        busy, done, err;
  logic [2:0]  err_code;
  logic [5:0]  err_pc;

  mvu_apb_cfg_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd_we(cmd_we), .cmd_waddr(cmd_waddr),
    .cmd_wdata(cmd_wdata), .start(start), .timeout_cycles(timeout_cycles),
    .irq(irq), .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .err_pc(err_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; bit wr; logic [31:0] wdata; } apb_t;
  typedef struct { bit done; bit err; int code; int pc; int busy; } end_t;

  apb_t exp_apb[$];
  end_t exp_end[$];
  int   checks = 0;
  int   errors = 0;

  int          scr_op   [64];
  logic [31:0] scr_addr [64];
  logic [31:0] scr_data [64];
  int          waits[$];
  int          pulse_bit[$];
  int          pulse_cyc[$];
  int          slv_idx;
  logic [31:0] rd_val [int];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rdv(input logic [31:0] a);
    return rd_val.exists(int'(a)) ? rd_val[int'(a)] : 32'h0;
  endfunction

  task automatic clear_stim();
    waits.delete(); pulse_bit.delete(); pulse_cyc.delete(); rd_val.delete();
    slv_idx = -1;
  endtask

  task automatic put(input int i, input int op, input logic [31:0] a, input logic [31:0] d);
    scr_op[i] = op; scr_addr[i] = a; scr_data[i] = d;
  endtask

  // Reference model: walks the script with per-command cycle costs.
  task automatic model(input int tmo);
    int pc, t, txn, ecode, op, w, s, x, need;
    int lastclr[8];
    logic [31:0] mask, a, d;
    bit fin, adv;
    end_t e;
    pc = 0; t = 0; txn = 0; mask = '1; fin = 0;
    e = '{0, 0, 0, 0, 0};
    for (int b = 0; b < 8; b++) lastclr[b] = 0;
    while (!fin) begin
      op = scr_op[pc]; a = scr_addr[pc]; d = scr_data[pc];
      adv = 0; ecode = 0;
      t += 2;
      case (op)
        0: begin e.done = 1; fin = 1; end
        1, 2: begin
          w = (txn < waits.size()) ? waits[txn] : 0;
          if (tmo != 0 && w + 1 > tmo) begin
            t += 1 + tmo; ecode = 3;
          end else begin
            t += 2 + w;
            exp_apb.push_back('{a, op == 1, d});
            if (txn == slv_idx) ecode = 1;
            else if (op == 2 && ((rdv(a) ^ d) & mask) != 0) ecode = 2;
            else adv = 1;
            txn++;
          end
        end
        3: begin mask = d; adv = 1; end
        4: begin
          s = t + 1; x = s;
          for (int b = 0; b < 8; b++) begin
            if (d[b]) begin
              need = 1 << 28;
              for (int p = 0; p < pulse_bit.size(); p++)
                if (pulse_bit[p] == b && pulse_cyc[p] > lastclr[b] && pulse_cyc[p] < need)
                  need = pulse_cyc[p];
              if (need + 1 > x) x = need + 1;
            end
          end
          if (tmo != 0 && x - s + 1 > tmo) begin
            t += tmo; ecode = 3;
          end else begin
            t = x; adv = 1;
            for (int b = 0; b < 8; b++) if (d[b]) lastclr[b] = x;
          end
        end
        5: begin t += int'(d) + 1; adv = 1; end
        default: ecode = 4;
      endcase
      if (adv) begin
        if (pc == 63) ecode = 5;
        else pc++;
      end
      if (ecode != 0) begin
        e.err = 1; e.code = ecode; e.pc = pc; fin = 1;
      end
    end
    e.busy = t;
    exp_end.push_back(e);
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      cmd_we = 1'b1; cmd_waddr = 6'(i);
      cmd_wdata = {3'(scr_op[i]), scr_addr[i], scr_data[i]};
      @(posedge clk); #1;
    end
    cmd_we = 1'b0;
  endtask

  task automatic do_run(input int n, input int tmo, input string tag);
    int k, txn, acc, wcur;
    bit finished;
    load(n);
    timeout_cycles = 20'(tmo);
    model(tmo);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0; txn = 0; acc = 0; wcur = 0; finished = 0;
    for (int c = 0; c < 5000 && !finished; c++) begin
      k++;
      if (done || err) begin
        finished = 1;
      end else begin
        irq = '0;
        for (int p = 0; p < pulse_cyc.size(); p++)
          if (pulse_cyc[p] == k) irq[pulse_bit[p]] = 1'b1;
        pready = 1'b0; pslverr = 1'b0;
        if (psel && penable) begin
          if (acc == 0) wcur = (txn < waits.size()) ? waits[txn] : 0;
          if (acc == wcur) begin
            pready = 1'b1; pslverr = (txn == slv_idx); txn++; acc = 0;
          end else acc++;
        end else acc = 0;
        prdata = rdv(paddr);
        @(posedge clk); #1;
      end
    end
    irq = '0; pready = 1'b0; pslverr = 1'b0;
    if (!finished) begin
      errors++; checks++;
      $display("FAIL run_%s_hang: got busy after 5000 cycles expected done or err", tag);
    end
    $display("run %s: done=%0d err=%0d code=%0d pc=%0d", tag, done, err, err_code, err_pc);
    @(posedge clk); #1;
  endtask

  // Monitor: compares each completed APB transfer and each run outcome.
  apb_t mon_a;
  end_t mon_e;
  bit   prev_end = 0, prev_busy = 0;
  int   busy_cnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_end = 0; prev_busy = 0;
    end else begin
      if (busy) busy_cnt = prev_busy ? busy_cnt + 1 : 1;
      if (psel && penable && pready) begin
        $display("apb wr=%0d addr=%08h wdata=%08h rdata=%08h slverr=%0d",
                 pwrite, paddr, pwdata, prdata, pslverr);
        if (exp_apb.size() == 0) begin
          errors++; checks++;
          $display("FAIL apb_unexpected: got transfer addr=%08h expected none", paddr);
        end else begin
          mon_a = exp_apb.pop_front();
          chk("apb_addr", paddr, mon_a.addr);
          chk("apb_write", pwrite, mon_a.wr);
          if (mon_a.wr) chk("apb_wdata", pwdata, mon_a.wdata);
        end
      end
      if ((done || err) && !prev_end) begin
        if (exp_end.size() == 0) begin
          errors++; checks++;
          $display("FAIL end_unexpected: got done=%0d err=%0d expected none", done, err);
        end else begin
          mon_e = exp_end.pop_front();
          chk("end_done", done, mon_e.done);
          chk("end_err", err, mon_e.err);
          chk("end_err_code", err_code, mon_e.code);
          chk("end_err_pc", err_pc, mon_e.pc);
          chk("end_busy_cycles", busy_cnt, mon_e.busy);
          chk("end_psel_low", psel, 0);
          chk("end_busy_low", busy, 0);
        end
      end
      prev_end = done || err;
      prev_busy = busy;
    end
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n, r, b1, b2;
    rst_n = 1'b0; cmd_we = 1'b0; cmd_waddr = '0; cmd_wdata = '0; start = 1'b0;
    timeout_cycles = '0; irq = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    #1;
    chk("rst_psel", psel, 0); chk("rst_penable", penable, 0); chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0); chk("rst_pwdata", pwdata, 0); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0); chk("rst_err", err, 0);
    chk("rst_err_code", err_code, 0); chk("rst_err_pc", err_pc, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Two writes then END.
    clear_stim();
    put(0, 1, 32'h10, 32'hA5); put(1, 1, 32'h14, 32'h3C); put(2, 0, 0, 0);
    do_run(3, 0, "two_writes");

    // Masked read-back: pass, then mismatch in the low bit.
    clear_stim();
    put(0, 3, 0, 32'h0000_FFFF); put(1, 2, 32'h20, 32'h1234); put(2, 0, 0, 0);
    rd_val[32'h20] = 32'hFFFF_1234;
    do_run(3, 0, "mask_pass");
    clear_stim();
    rd_val[32'h20] = 32'h0000_1235;
    do_run(3, 0, "mask_mismatch");

    // Interrupt waits: early irq[0]/irq[1], late irq[2]; second wait uses the kept irq[1].
    clear_stim();
    put(0, 5, 0, 10); put(1, 4, 0, 32'h05); put(2, 4, 0, 32'h02); put(3, 0, 0, 0);
    pulse_bit = '{0, 1, 2}; pulse_cyc = '{5, 6, 66};
    do_run(4, 0, "wait_irq");

    // Watchdog: expires, boundary where pready wins, and disabled.
    clear_stim();
    put(0, 1, 32'h40, 32'h77); put(1, 0, 0, 0);
    waits.push_back(1000);
    do_run(2, 100, "timeout_100");
    clear_stim(); waits.push_back(99);
    do_run(2, 100, "pready_same_cycle");
    clear_stim(); waits.push_back(150);
    do_run(2, 0, "timeout_off");

    // Slave error on the second write, then illegal opcode on rerun.
    clear_stim();
    put(0, 1, 32'h00, 32'h1); put(1, 1, 32'h04, 32'h2); put(2, 7, 32'h08, 32'h3);
    slv_idx = 1;
    do_run(3, 0, "slverr");
    clear_stim();
    do_run(3, 0, "bad_op");

    // Full RAM of writes with no END.
    clear_stim();
    for (int i = 0; i < 64; i++) put(i, 1, 32'(i * 4), 32'(i * 3 + 1));
    do_run(64, 0, "overrun");

    // Randomized scripts.
    for (int run = 0; run < 25; run++) begin
      clear_stim();
      n = $urandom_range(3, 12);
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, 29);
        if (r < 8) put(i, 1, 32'($urandom_range(0, 15) * 4), $urandom);
        else if (r < 14) begin
          put(i, 2, 32'($urandom_range(0, 15) * 4), $urandom);
          rd_val[int'(scr_addr[i])] = scr_data[i] ^
            (($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0);
        end
        else if (r < 17) put(i, 3, 0, $urandom);
        else if (r < 22) put(i, 5, 0, 32'($urandom_range(0, 5)));
        else if (r < 27) begin
          b1 = $urandom_range(0, 7); b2 = $urandom_range(0, 7);
          put(i, 4, 0, (32'h1 << b1) | (32'h1 << b2));
        end
        else if (r < 28) put(i, $urandom_range(6, 7), 0, 0);
        else put(i, 1, 32'h3C, $urandom);
      end
      put(n, 0, 0, 0);
      for (int i = 0; i < 16; i++) waits.push_back($urandom_range(0, 3));
      for (int i = 0; i < 8; i++) begin
        pulse_bit.push_back($urandom_range(0, 7));
        pulse_cyc.push_back($urandom_range(1, 120));
      end
      if ($urandom_range(0, 9) == 0) slv_idx = $urandom_range(0, 4);
      do_run(n + 1, ($urandom_range(1, 3) == 1) ? $urandom_range(2, 5) : 200, "random");
    end

    // Reset asserted while a transfer sits in ACCESS.
    clear_stim();
    put(0, 1, 32'h50, 32'hDEAD_BEEF); put(1, 0, 0, 0);
    load(2);
    timeout_cycles = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 20 && !(psel && penable); i++) begin
      @(posedge clk); #1;
    end
    chk("midrst_in_access", psel && penable, 1);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midrst_psel", psel, 0); chk("midrst_penable", penable, 0);
    chk("midrst_pwrite", pwrite, 0); chk("midrst_paddr", paddr, 0);
    chk("midrst_pwdata", pwdata, 0); chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0); chk("midrst_err", err, 0);
    $display("reset mid-access: psel=%0d busy=%0d", psel, busy);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Recovery after reset.
    clear_stim();
    put(0, 1, 32'h10, 32'hA5); put(1, 1, 32'h14, 32'h3C); put(2, 0, 0, 0);
    do_run(3, 0, "after_reset");

    chk("exp_apb_left", exp_apb.size(), 0);
    chk("exp_end_left", exp_end.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
